// File: rtl/token_encoder.sv
// token_encoder: vocabulary tokenizer driving input, vocab and output SRAMs.
// Splits a delimited string into words and writes one token ID per word.
module token_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_ADDR_WIDTH = 4,
  parameter int VOCAB_ENTRIES = 16,
  parameter int MAX_WORD_LEN = 4,
  parameter int OUT_ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] DELIM = 8'h20,
  localparam int ID_WIDTH = $clog2(VOCAB_ENTRIES + 1),
  localparam int VA_WIDTH = $clog2(VOCAB_ENTRIES * MAX_WORD_LEN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [OUT_ADDR_WIDTH:0]   token_count,
  output logic [IN_ADDR_WIDTH-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0]     in_rdata,
  output logic [VA_WIDTH-1:0]       v_addr,
  input  logic [DATA_WIDTH-1:0]     v_rdata,
  output logic                      out_we,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr,
  output logic [ID_WIDTH-1:0]       out_wdata
);

  localparam int WL_W = $clog2(MAX_WORD_LEN + 1);
  localparam int KW =
    (MAX_WORD_LEN > 1) ? $clog2(MAX_WORD_LEN) : 1;
  localparam int TC_W = OUT_ADDR_WIDTH + 1;
  localparam logic [ID_WIDTH-1:0] UNK_ID =
    ID_WIDTH'(VOCAB_ENTRIES);
  localparam logic [ID_WIDTH-1:0] LAST_E =
    ID_WIDTH'(VOCAB_ENTRIES - 1);
  localparam logic [WL_W-1:0] MAXL = WL_W'(MAX_WORD_LEN);
  localparam logic [IN_ADDR_WIDTH-1:0] LAST_IN = '1;
  localparam logic [TC_W-1:0] CAP =
    {1'b1, {OUT_ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_LOAD,
    S_MATCH,
    S_EMIT,
    S_FINISH
  } state_t;

  state_t state, nxt;

  logic                  rd_vld;
  logic                  v_vld;
  logic                  too_long;
  logic                  term_delim;
  logic [DATA_WIDTH-1:0] word_buf [MAX_WORD_LEN];
  logic [WL_W-1:0]       word_len;
  logic [ID_WIDTH-1:0]   ent;
  logic [ID_WIDTH-1:0]   id;
  logic [KW-1:0]         k;

  logic                  is_zero;
  logic                  is_delim;
  logic                  in_last;
  logic                  load_stop;
  logic                  long_next;
  logic                  full;
  logic                  byte_ok;
  logic                  last_k;
  logic [WL_W-1:0]       klast;
  logic [DATA_WIDTH-1:0] exp_b;
  logic [VA_WIDTH-1:0]   next_base;

  // Character classification and per-byte vocab comparison
  always_comb begin
    is_zero   = in_rdata == '0;
    is_delim  = in_rdata == DELIM;
    in_last   = in_addr == LAST_IN;
    load_stop = is_zero | is_delim;
    long_next = too_long |
                (!load_stop && word_len == MAXL);
    full      = token_count == CAP;
    klast     = (word_len == MAXL) ?
                MAXL - WL_W'(1) : word_len;
    exp_b     = (WL_W'(k) < word_len) ?
                word_buf[k] : '0;
    byte_ok   = v_rdata == exp_b;
    last_k    = WL_W'(k) == klast;
    next_base = VA_WIDTH'((int'(ent) + 1) * MAX_WORD_LEN);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state decode; reads wait one cycle for SRAM data
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start) nxt = S_SKIP;
      S_SKIP: begin
        if (rd_vld) begin
          unique case (1'b1)
            is_zero:  nxt = S_FINISH;
            is_delim: nxt = in_last ? S_FINISH : S_SKIP;
            default:  nxt = S_LOAD;
          endcase
        end
      end
      S_LOAD: begin
        if (rd_vld && (load_stop || in_last))
          nxt = long_next ? S_EMIT : S_MATCH;
      end
      S_MATCH: begin
        if (v_vld) begin
          if (!byte_ok) begin
            if (ent == LAST_E) nxt = S_EMIT;
          end else if (last_k) begin
            nxt = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (full)            nxt = S_FINISH;
        else if (term_delim) nxt = S_SKIP;
        else                 nxt = S_FINISH;
      end
      S_FINISH: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Datapath: addresses, word buffer, match search, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_addr     <= '0;
      v_addr      <= '0;
      rd_vld      <= 1'b0;
      v_vld       <= 1'b0;
      too_long    <= 1'b0;
      term_delim  <= 1'b0;
      word_len    <= '0;
      ent         <= '0;
      id          <= '0;
      k           <= '0;
      token_count <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < MAX_WORD_LEN; i++)
        word_buf[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            in_addr     <= '0;
            rd_vld      <= 1'b0;
            token_count <= '0;
            overflow    <= 1'b0;
          end
        end
        S_SKIP: begin
          if (!rd_vld) begin
            rd_vld <= 1'b1;
          end else if (is_delim) begin
            if (!in_last) begin
              in_addr <= in_addr + IN_ADDR_WIDTH'(1);
              rd_vld  <= 1'b0;
            end
          end else if (!is_zero) begin
            word_len <= '0;
            too_long <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!rd_vld) begin
            rd_vld <= 1'b1;
          end else begin
            if (!load_stop) begin
              if (word_len < MAXL) begin
                word_buf[word_len[KW-1:0]] <= in_rdata;
                word_len <= word_len + WL_W'(1);
              end else begin
                too_long <= 1'b1;
              end
            end
            if (load_stop || in_last) begin
              term_delim <= is_delim;
              ent        <= '0;
              k          <= '0;
              v_addr     <= '0;
              v_vld      <= 1'b0;
              id         <= UNK_ID;
            end else begin
              in_addr <= in_addr + IN_ADDR_WIDTH'(1);
              rd_vld  <= 1'b0;
            end
          end
        end
        S_MATCH: begin
          if (!v_vld) begin
            v_vld <= 1'b1;
          end else if (!byte_ok) begin
            if (ent != LAST_E) begin
              ent    <= ent + ID_WIDTH'(1);
              k      <= '0;
              v_addr <= next_base;
              v_vld  <= 1'b0;
            end
          end else if (last_k) begin
            id <= ent;
          end else begin
            k      <= k + KW'(1);
            v_addr <= v_addr + VA_WIDTH'(1);
            v_vld  <= 1'b0;
          end
        end
        S_EMIT: begin
          if (full) overflow <= 1'b1;
          else      token_count <= token_count + TC_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake and output-SRAM write port
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    out_we    = 1'b0;
    out_addr  = token_count[OUT_ADDR_WIDTH-1:0];
    out_wdata = id;
    unique case (state)
      S_SKIP, S_LOAD, S_MATCH: busy = 1'b1;
      S_EMIT: begin
        busy   = 1'b1;
        out_we = !full;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule
